ask_frame_sync: RTL

- Downstream of the ASK/AM demodulator top; consumes its bit_out/bit_valid stream when the signal is classified as ASK.
- Hunts for a sync word, de-serialises a fixed-length payload MSB-first, and buffers payload bytes in a FIFO.
- The FIFO drains through a valid/ready byte interface to the display/UART stage.
- Keeps good-frame and overflow status for the UI.

---
 rtl/ask_frame_sync.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ask_frame_sync.sv
// Sync-word hunter, MSB-first payload deserialiser and show-ahead byte FIFO for the ASK bit stream.
// Define ASK_FRAME_CHK_EN to expect an XOR check byte per frame and commit whole frames atomically.
module ask_frame_sync #(
    parameter logic [7:0]  SYNC_WORD     = 8'hA5,
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          bit_in,
    input  logic          bit_in_valid,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic          in_frame,
    output logic [7:0]    frame_cnt,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    shreg;
    logic [7:0]    shin;
    logic [3:0]    hunt_cnt;
    logic [3:0]    hunt_inc;
    logic [2:0]    bit_cnt;
    logic [LW-1:0] byte_cnt;
    logic          bit_stb;
    logic          sync_hit;
    logic          last_bit;
    logic          last_byte;
    logic          full;
    logic          wr_c;
    logic          drop_c;
    logic          done_c;
    logic          clr_c;
    logic          wr_req;
    logic [7:0]    wr_data;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [LW-1:0] tent_ptr;
    logic [LW-1:0] cmt_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] rd_next;
    logic          pop;
`ifdef ASK_FRAME_CHK_EN
    logic          rb_c;
    logic          rb_req;
    logic          cm_req;
    logic [7:0]    chk_acc;
`endif

    always_comb begin
        bit_stb   = en & bit_in_valid;
        shin      = {shreg[6:0], bit_in};
        hunt_inc  = (hunt_cnt == 4'd8) ? 4'd8 : hunt_cnt + 4'd1;
        sync_hit  = (hunt_inc == 4'd8) && (shin == SYNC_WORD);
        last_bit  = (bit_cnt == 3'd7);
        last_byte = (byte_cnt == LW'(PAYLOAD_BYTES - 1));
        full      = ((tent_ptr - rd_ptr) == LW'(FIFO_DEPTH));
        pop       = byte_valid & byte_ready;
        rd_next   = rd_ptr + LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HUNT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HUNT:    if (bit_stb && sync_hit) state_next = S_PAYLOAD;
            S_PAYLOAD: if (bit_stb && last_bit && (full || last_byte)) begin
`ifdef ASK_FRAME_CHK_EN
                state_next = full ? S_HUNT : S_CHECK;
`else
                state_next = S_HUNT;
`endif
            end
`ifdef ASK_FRAME_CHK_EN
            S_CHECK:   if (bit_stb && last_bit) state_next = S_HUNT;
`endif
            default:   state_next = S_HUNT;
        endcase
        if (!en) state_next = S_HUNT;
    end

    // Strobes into the datapath; clr_c also wipes partial sync when en drops in HUNT.
    always_comb begin
        wr_c   = 1'b0;
        drop_c = 1'b0;
        done_c = 1'b0;
        clr_c  = (state_next == S_HUNT) && ((state != S_HUNT) || !en);
        case (state)
            S_PAYLOAD: if (bit_stb && last_bit) begin
                if (full) begin
                    drop_c = 1'b1;
                end else begin
                    wr_c = 1'b1;
`ifndef ASK_FRAME_CHK_EN
                    done_c = last_byte;
`endif
                end
            end
`ifdef ASK_FRAME_CHK_EN
            S_CHECK:   if (bit_stb && last_bit && (shin == chk_acc)) done_c = 1'b1;
`endif
            default: ;
        endcase
`ifdef ASK_FRAME_CHK_EN
        rb_c = (state != S_HUNT) &&
               (!en || drop_c || ((state == S_CHECK) && bit_stb && last_bit && !done_c));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= 8'h00;
            hunt_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            wr_req    <= 1'b0;
            wr_data   <= 8'h00;
            in_frame  <= 1'b0;
            frame_cnt <= 8'h00;
            overflow  <= 1'b0;
`ifdef ASK_FRAME_CHK_EN
            rb_req    <= 1'b0;
            cm_req    <= 1'b0;
            chk_acc   <= 8'h00;
`endif
        end else begin
            if (clr_c) begin
                shreg    <= 8'h00;
                hunt_cnt <= 4'd0;
            end else if (bit_stb) begin
                shreg <= shin;
                if (state == S_HUNT) hunt_cnt <= hunt_inc;
            end
            if (state == S_HUNT) bit_cnt <= 3'd0;
            else if (bit_stb)    bit_cnt <= bit_cnt + 3'd1;
            if (state == S_HUNT) byte_cnt <= '0;
            else if (wr_c)       byte_cnt <= byte_cnt + LW'(1);
            wr_req   <= wr_c;
            wr_data  <= shin;
            in_frame <= (state_next != S_HUNT);
            if (done_c) frame_cnt <= frame_cnt + 8'd1;
            if (drop_c) overflow  <= 1'b1;
`ifdef ASK_FRAME_CHK_EN
            rb_req <= rb_c;
            cm_req <= done_c;
            if (state == S_HUNT) chk_acc <= 8'h00;
            else if (wr_c)       chk_acc <= chk_acc ^ shin;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req) mem[tent_ptr[AW-1:0]] <= wr_data;
    end

    // Read side tracks the committed pointer as it stood before this edge, giving one extra cycle after a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tent_ptr   <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            byte_valid <= 1'b0;
            byte_out   <= 8'h00;
            fifo_level <= '0;
        end else begin
            rd_ptr     <= rd_next;
            byte_valid <= (cmt_ptr != rd_next);
            byte_out   <= (cmt_ptr != rd_next) ? mem[rd_next[AW-1:0]] : 8'h00;
            fifo_level <= cmt_ptr - rd_next;
            if (wr_req) begin
                tent_ptr <= tent_ptr + LW'(1);
`ifndef ASK_FRAME_CHK_EN
                cmt_ptr  <= tent_ptr + LW'(1);
`endif
            end
`ifdef ASK_FRAME_CHK_EN
            else if (rb_req) tent_ptr <= cmt_ptr;
            else if (cm_req) cmt_ptr  <= tent_ptr;
`endif
        end
    end
endmodule
